// File: rtl/sampler_pkg.sv
// Shared definitions for the sensor sampler: sequencer state encodings,
// SPI frame geometry, channel codes, reset values and small helpers.
package sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam logic       CMD_START   = 1'b1;
  localparam int         FRAME_BITS  = 16;
  localparam int         DATA_BITS   = 8;
  localparam logic       CH_MOIST    = 1'b0;
  localparam logic       CH_LIGHT    = 1'b1;
  localparam logic [7:0] M_SENSE_RST = 8'd255;
  localparam logic [1:0] L_DAY       = 2'b01;
  localparam logic [1:0] L_NIGHT     = 2'b00;

  // Command byte sent in frame bits 15..8 for the selected channel.
  function automatic logic [7:0] cmd_byte(input logic ch);
    return {CMD_START, ch, 6'b000000};
  endfunction

  // Day/night code; only the two legal codes can ever be returned.
  function automatic logic [1:0] light_code(input logic [7:0] sample,
                                            input logic [7:0] level);
    if (sample >= level) begin
      return L_DAY;
    end else begin
      return L_NIGHT;
    end
  endfunction

  // Two-point average with a 9-bit sum so the carry is not lost; truncates.
  function automatic logic [7:0] avg_sample(input logic [7:0] prev,
                                            input logic [7:0] sample);
    logic [8:0] sum;
    sum = {1'b0, prev} + {1'b0, sample};
    return sum[8:1];
  endfunction

endpackage

// File: rtl/spi_frame.sv
// One 16-bit SPI transaction, MSB first, two clk cycles per bit
// (sclk low then high). A start pulse opens the frame with a one-cycle
// setup phase; done marks the final high phase, and rx_o then carries the
// last eight MISO bits including the one being sampled in that cycle.
module spi_frame
  import sampler_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [7:0]           cmd_i,
  input  logic                 miso_i,
  output logic                 cs_n_o,
  output logic                 sclk_o,
  output logic                 mosi_o,
  output logic                 done_o,
  output logic [DATA_BITS-1:0] rx_o
);

  // Bits still to be sent after the one currently on mosi.
  localparam int TX_W = FRAME_BITS - 1;
  // The final data bit comes straight from miso in the done cycle,
  // so only the seven before it need storage.
  localparam int RX_W = DATA_BITS - 1;

  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            setup_q, setup_d;
  logic [3:0]      bit_q, bit_d;
  logic [TX_W-1:0] tx_q, tx_d;
  logic [RX_W-1:0] rx_q, rx_d;

  assign done_o = !cs_n_q && !setup_q && sclk_q && (bit_q == 4'd0);
  assign rx_o   = {rx_q, miso_i};
  assign cs_n_o = cs_n_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

  // Frame sequencing: mosi only moves when sclk is about to go low.
  always_comb begin
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    setup_d = setup_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    if (start_i) begin
      cs_n_d  = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = cmd_i[7];
      tx_d    = {cmd_i[6:0], {DATA_BITS{1'b0}}};
      bit_d   = 4'(FRAME_BITS - 1);
      setup_d = 1'b1;
      rx_d    = {RX_W{1'b0}};
    end else if (cs_n_q) begin
      sclk_d = 1'b0;
      mosi_d = 1'b0;
    end else if (setup_q) begin
      setup_d = 1'b0;
    end else if (!sclk_q) begin
      sclk_d = 1'b1;
    end else begin
      rx_d   = {rx_q[RX_W-2:0], miso_i};
      sclk_d = 1'b0;
      if (bit_q == 4'd0) begin
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
      end else begin
        bit_d  = bit_q - 4'd1;
        mosi_d = tx_q[TX_W-1];
        tx_d   = {tx_q[TX_W-2:0], 1'b0};
      end
    end
  end

  // Frame registers with synchronous reset to an idle, deselected bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      setup_q <= 1'b0;
      bit_q   <= 4'd0;
      tx_q    <= {TX_W{1'b0}};
      rx_q    <= {RX_W{1'b0}};
    end else begin
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      setup_q <= setup_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

endmodule

// File: rtl/sensor_sampler.sv
// Periodic two-channel ADC sampler. A sample set is a moisture frame, a
// one-cycle gap, a light frame and a final gap in which all three sensor
// outputs update together with a one-cycle sample_valid pulse.
// Optional build macro SAMPLER_AVG_EN: moisture output is the average of
// the previous published value and the new sample (raw on the first set).
module sensor_sampler
  import sampler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] sample_period,
  input  logic [7:0] light_level,
  input  logic       adc_miso,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_mosi,
  output logic [7:0] m_sense,
  output logic [7:0] l_sense,
  output logic [1:0] l_thresh,
  output logic       sample_valid
);

  state_e               state_q, state_d;
  logic [7:0]           count_q, count_d;
  logic                 ch_q, ch_d;
  logic [DATA_BITS-1:0] moist_q, moist_d;
  logic [DATA_BITS-1:0] m_sense_q, m_sense_d;
  logic [DATA_BITS-1:0] l_sense_q, l_sense_d;
  logic [1:0]           l_thresh_q, l_thresh_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] m_pub_s;
  logic                 start_s;
  logic [7:0]           cmd_s;
  logic                 frame_done_s;
  logic [DATA_BITS-1:0] rx_byte_s;
`ifdef SAMPLER_AVG_EN
  logic                 first_q, first_d;
`endif

  spi_frame u_frame (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_s),
    .cmd_i   (cmd_s),
    .miso_i  (adc_miso),
    .cs_n_o  (adc_cs_n),
    .sclk_o  (adc_sclk),
    .mosi_o  (adc_mosi),
    .done_o  (frame_done_s),
    .rx_o    (rx_byte_s)
  );

  // Moisture value that the next publish will present.
  always_comb begin
`ifdef SAMPLER_AVG_EN
    if (first_q) begin
      m_pub_s = moist_q;
    end else begin
      m_pub_s = avg_sample(m_sense_q, moist_q);
    end
`else
    m_pub_s = moist_q;
`endif
  end

  // Sequencer: period timer, channel order, frame launch and publish.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ch_d       = ch_q;
    moist_d    = moist_q;
    m_sense_d  = m_sense_q;
    l_sense_d  = l_sense_q;
    l_thresh_d = l_thresh_q;
    valid_d    = 1'b0;
    start_s    = 1'b0;
    cmd_s      = cmd_byte(ch_q);
`ifdef SAMPLER_AVG_EN
    first_d    = first_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Period compared live; enable is only consulted here, so a set
        // already under way always runs to completion.
        if (enable && (count_q >= sample_period)) begin
          count_d = 8'd0;
          ch_d    = CH_MOIST;
          start_s = 1'b1;
          cmd_s   = cmd_byte(CH_MOIST);
          state_d = ST_SETUP;
        end else if (count_q != 8'hFF) begin
          count_d = count_q + 8'd1;
        end else begin
          count_d = count_q;
        end
      end
      ST_SETUP: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (frame_done_s) begin
          state_d = ST_GAP;
          if (ch_q == CH_LIGHT) begin
            m_sense_d  = m_pub_s;
            l_sense_d  = rx_byte_s;
            l_thresh_d = light_code(rx_byte_s, light_level);
            valid_d    = 1'b1;
`ifdef SAMPLER_AVG_EN
            first_d    = 1'b0;
`endif
          end else begin
            moist_d = rx_byte_s;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (ch_q == CH_MOIST) begin
          ch_d    = CH_LIGHT;
          start_s = 1'b1;
          cmd_s   = cmd_byte(CH_LIGHT);
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and output registers; reset drops any partial set silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= 8'd0;
      ch_q       <= CH_MOIST;
      moist_q    <= 8'd0;
      m_sense_q  <= M_SENSE_RST;
      l_sense_q  <= 8'd0;
      l_thresh_q <= L_NIGHT;
      valid_q    <= 1'b0;
`ifdef SAMPLER_AVG_EN
      first_q    <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ch_q       <= ch_d;
      moist_q    <= moist_d;
      m_sense_q  <= m_sense_d;
      l_sense_q  <= l_sense_d;
      l_thresh_q <= l_thresh_d;
      valid_q    <= valid_d;
`ifdef SAMPLER_AVG_EN
      first_q    <= first_d;
`endif
    end
  end

  assign m_sense      = m_sense_q;
  assign l_sense      = l_sense_q;
  assign l_thresh     = l_thresh_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_sensor_sampler.sv
// Self-checking bench for sensor_sampler: an SPI ADC model answering per
// channel, a scoreboard of expected published sets, and directed steps.
module tb_sensor_sampler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] sample_period;
  logic [7:0] light_level;
  logic       adc_miso = 1'b0;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic       adc_mosi;
  logic [7:0] m_sense;
  logic [7:0] l_sense;
  logic [1:0] l_thresh;
  logic       sample_valid;

  sensor_sampler dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_period(sample_period),
    .light_level  (light_level),
    .adc_miso     (adc_miso),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .adc_mosi     (adc_mosi),
    .m_sense      (m_sense),
    .l_sense      (l_sense),
    .l_thresh     (l_thresh),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] l;
    logic [1:0] th;
  } exp_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         valid_cnt = 0;
  int         cs_fall_cnt = 0;
  int         rise_cnt = 0;
  int         bit_idx = 0;
  int         mosi_bad = 0;
  exp_t       exp_q[$];
  logic [7:0] cmd_q[$];
  logic [7:0] adc_moist = 8'd0;
  logic [7:0] adc_light = 8'd0;
  logic [7:0] adc_hi = 8'hA5;
  logic [7:0] m_prev = 8'd0;
  logic       first_set = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard push: program the ADC and record the set it must publish.
  task automatic push_set(input logic [7:0] moist, input logic [7:0] light);
    exp_t e;
`ifdef SAMPLER_AVG_EN
    logic [8:0] sum;
    if (first_set) begin
      e.m = moist;
    end else begin
      sum = {1'b0, m_prev} + {1'b0, moist};
      e.m = sum[8:1];
    end
`else
    e.m = moist;
`endif
    e.l  = light;
    e.th = (light >= light_level) ? 2'b01 : 2'b00;
    m_prev    = e.m;
    first_set = 1'b0;
    adc_moist = moist;
    adc_light = light;
    exp_q.push_back(e);
  endtask

  // ADC model, evaluated between clock edges from the observed bus levels.
  always @(negedge clk) begin : adc_model
    logic       prev_cs;
    logic       prev_sclk;
    logic [7:0] cmd_sh;
    logic [7:0] val;
    if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
      cs_fall_cnt++;
      rise_cnt = 0;
      cmd_sh   = 8'h00;
      bit_idx  = 15;
      adc_miso = adc_hi[7];
    end else if (adc_cs_n === 1'b0 && prev_sclk === 1'b0 && adc_sclk === 1'b1) begin
      rise_cnt++;
      if (rise_cnt <= 8) cmd_sh = {cmd_sh[6:0], adc_mosi};
      if (rise_cnt == 8) cmd_q.push_back(cmd_sh);
      if (rise_cnt > 8 && adc_mosi !== 1'b0) mosi_bad++;
    end else if (adc_cs_n === 1'b0 && prev_sclk === 1'b1 && adc_sclk === 1'b0) begin
      bit_idx--;
      if (bit_idx >= 8) begin
        adc_miso = adc_hi[bit_idx-8];
      end else if (bit_idx >= 0) begin
        val      = cmd_sh[6] ? adc_light : adc_moist;
        adc_miso = val[bit_idx];
      end
    end
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  // Output monitor: every sample_valid pulse pops and checks one expected set.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sample_valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("m_sense", {24'd0, m_sense}, {24'd0, e.m});
        chk("l_sense", {24'd0, l_sense}, {24'd0, e.l});
        chk("l_thresh", {30'd0, l_thresh}, {30'd0, e.th});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cs_low(input string tag, output int t);
    int n = 0;
    @(negedge clk);
    while (adc_cs_n !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (adc_cs_n !== 1'b0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic wait_valid(input string tag, output int t);
    int n = 0;
    @(negedge clk);
    while (sample_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sample_valid !== 1'b1) chk({tag, "_timeout"}, 32'd0, 32'd1);
    t = cyc;
  endtask

  initial begin : stim
    int t0;
    int t1;
    int t2;
    int v0;
    int f0;
    int n;
    logic [7:0] c;

    reset         = 1'b1;
    enable        = 1'b0;
    sample_period = 8'd0;
    light_level   = 8'd128;
    cycles(3);

    // Reset state
    chk("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, adc_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, adc_mosi}, 32'd0);
    chk("rst_m_sense", {24'd0, m_sense}, 32'd255);
    chk("rst_l_sense", {24'd0, l_sense}, 32'd0);
    chk("rst_l_thresh", {30'd0, l_thresh}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    reset = 1'b0;

    // Basic set, period 0: latency from moisture cs fall to publish
    push_set(8'd50, 8'd200);
    enable = 1'b1;
    wait_cs_low("a_cs", t0);
    wait_valid("a_valid", t1);
    enable = 1'b0;
    chk("a_latency", t1 - t0, 32'd67);
    cycles(20);
    chk("a_hold_m", {24'd0, m_sense}, 32'd50);
    chk("a_idle_cs", {31'd0, adc_cs_n}, 32'd1);

    // Period 10: pulse spacing and command bytes
    sample_period = 8'd10;
    cmd_q.delete();
    push_set(8'd50, 8'd200);
    push_set(8'd50, 8'd200);
    enable = 1'b1;
    wait_valid("b_valid1", t1);
    wait_valid("b_valid2", t2);
    enable = 1'b0;
    chk("b_spacing", t2 - t1, 32'd79);
    cycles(5);
    chk("b_cmd_count", cmd_q.size(), 32'd4);
    if (cmd_q.size() >= 2) begin
      c = cmd_q.pop_front();
      chk("b_cmd_moist", {24'd0, c}, 32'h80);
      c = cmd_q.pop_front();
      chk("b_cmd_light", {24'd0, c}, 32'hC0);
    end

    // Threshold boundary: equal is day, one below is night
    sample_period = 8'd0;
    push_set(8'd60, 8'd128);
    enable = 1'b1;
    wait_valid("c_eq_valid", t1);
    enable = 1'b0;
    cycles(3);
    push_set(8'd70, 8'd127);
    enable = 1'b1;
    wait_valid("c_lt_valid", t1);
    enable = 1'b0;
    cycles(3);

    // Reset in the middle of the light frame discards the set
    adc_moist = 8'd10;
    adc_light = 8'd20;
    v0 = valid_cnt;
    f0 = cs_fall_cnt;
    enable = 1'b1;
    n = 0;
    while ((cs_fall_cnt < f0 + 2 || rise_cnt < 6) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("d_reached_light_frame", {31'd0, (cs_fall_cnt == f0 + 2)}, 32'd1);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    first_set = 1'b1;
    m_prev    = 8'd0;
    chk("d_cs_n", {31'd0, adc_cs_n}, 32'd1);
    chk("d_sclk", {31'd0, adc_sclk}, 32'd0);
    chk("d_m_sense", {24'd0, m_sense}, 32'd255);
    chk("d_l_sense", {24'd0, l_sense}, 32'd0);
    chk("d_valid", {31'd0, sample_valid}, 32'd0);
    cycles(100);
    chk("d_no_pulse", valid_cnt - v0, 32'd0);

    // Enable dropped during the moisture frame: set still completes once
    v0 = valid_cnt;
    f0 = cs_fall_cnt;
    push_set(8'd30, 8'd90);
    enable = 1'b1;
    wait_cs_low("e_cs", t0);
    cycles(5);
    enable = 1'b0;
    wait_valid("e_valid", t1);
    cycles(150);
    chk("e_pulse_count", valid_cnt - v0, 32'd1);
    chk("e_frame_count", cs_fall_cnt - f0, 32'd2);
    chk("e_cs_idle", {31'd0, adc_cs_n}, 32'd1);

    // Moisture 100 then 51 after a fresh reset
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    first_set = 1'b1;
    push_set(8'd100, 8'd200);
    enable = 1'b1;
    wait_valid("f_valid1", t1);
    enable = 1'b0;
    cycles(3);
    push_set(8'd51, 8'd200);
    enable = 1'b1;
    wait_valid("f_valid2", t2);
    enable = 1'b0;
    cycles(3);
`ifdef SAMPLER_AVG_EN
    chk("f_m_final", {24'd0, m_sense}, 32'd75);
`else
    chk("f_m_final", {24'd0, m_sense}, 32'd51);
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("mosi_tail_zero", mosi_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_sampler.md
SENSOR_SAMPLER -- requirements
Module: sensor_sampler

Interface
REQ-001 SHALL have clock and reset as: clk  in  1  system clock; reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
REQ-002 SHALL have: enable  in  1  periodic sampling permitted while high.
REQ-003 SHALL have: sample_period  in  8  idle clk cycles between sample sets; 0 means back-to-back sets.
REQ-004 SHALL have: light_level  in  8  daylight comparison level.
REQ-005 SHALL have: adc_miso  in  1  ADC serial data out.
REQ-006 SHALL have: adc_cs_n  out  1  ADC chip select, active low.
REQ-007 SHALL have: adc_sclk  out  1  SPI clock; idles low.
REQ-008 SHALL have: adc_mosi  out  1  ADC command data.
REQ-009 SHALL have: m_sense  out  8  latest moisture sample, feeds the watering FSM.
REQ-010 SHALL have: l_sense  out  8  latest light sample.
REQ-011 SHALL have: l_thresh  out  2  light code for the FSM: 2'b01 when day, 2'b00 when night.
REQ-012 SHALL have: sample_valid  out  1  one-cycle pulse when m_sense, l_sense and l_thresh update.

Function
REQ-013 SHALL run states IDLE, SETUP, SHIFT, GAP, with channel bit ch: 0 is moisture, 1 is light.
REQ-014 IDLE SHALL count clk cycles in an 8-bit counter.
- When enable=1 and count >= sample_period: clear count, ch=0, go to SETUP.
- sample_period is compared live, so lowering it below count starts a set on the next cycle.
REQ-015 SETUP SHALL last 1 cycle with adc_cs_n=0 and adc_sclk=0, driving the first command bit on adc_mosi.
REQ-016 SHIFT SHALL transfer 16 bits MSB first at 2 clk per bit.
- adc_sclk is low for 1 cycle, then high for 1 cycle.
- adc_mosi changes only while adc_sclk is low.
- adc_miso is sampled in the cycle adc_sclk is high (rising edge).
REQ-017 Frame bits 15..8 SHALL be the command {1'b1, ch, 6'b000000}; adc_mosi SHALL be 0 during bits 7..0.
REQ-018 MISO bits 7..0 SHALL form the 8-bit sample; MISO bits 15..8 SHALL be ignored.
REQ-019 After the 16th bit, adc_cs_n SHALL go high for exactly 1 GAP cycle.
- Moisture frame: GAP then SETUP with ch=1.
- Light frame: GAP then IDLE.
REQ-020 In the light frame's GAP cycle, m_sense, l_sense and l_thresh SHALL update together and sample_valid SHALL pulse for 1 cycle.
- m_sense and l_sense hold their values at all other times.
REQ-021 l_thresh SHALL be 2'b01 if light sample >= light_level, else 2'b00; 2'b1x SHALL never be produced.
REQ-022 Set latency SHALL be 67 cycles from the adc_cs_n falling edge of the moisture frame to sample_valid: 33 + 1 + 33.
REQ-023 Deasserting enable mid-set SHALL NOT abort the set; the set completes and publishes, then the block stays in IDLE.

Reset
REQ-024 reset SHALL force, on the next clk edge:
- State: IDLE, count=0, ch=0.
- Outputs: adc_cs_n=1, adc_sclk=0, adc_mosi=0, m_sense=8'd255 (wet, no watering), l_sense=0, l_thresh=2'b00, sample_valid=0.
REQ-025 Reset mid-frame SHALL discard the partial samples without any output update.

Configuration
REQ-026 Macro SAMPLER_AVG_EN defined:
- m_sense SHALL publish (previous m_sense + new moisture sample) >> 1, using a 9-bit sum and truncation.
- The first set after reset SHALL publish the raw sample.
REQ-027 Macro SAMPLER_AVG_EN undefined: m_sense SHALL publish the raw sample. l_sense SHALL be raw in both builds.

Structure
REQ-028 Shared package sampler_pkg SHALL hold:
- state encodings;
- CMD_START=1'b1;
- FRAME_BITS=16, DATA_BITS=8;
- CH_MOIST=0, CH_LIGHT=1;
- M_SENSE_RST=8'd255.
REQ-029 One sub-module spi_frame SHALL implement a single 16-bit transaction (cs_n/sclk/mosi/miso, start, done, rx byte). The sequencer, timer and output registers SHALL stay in sensor_sampler.

Verification
REQ-030 ADC model returns 8'd50 on ch 0 and 8'd200 on ch 1; light_level=128, sample_period=0, enable=1 -> sample_valid at cycle 67 after the first adc_cs_n fall, m_sense=50, l_sense=200, l_thresh=01.
REQ-031 Same setup with sample_period=10 -> consecutive sample_valid pulses exactly 68+11 cycles apart; command bytes observed are 8'h80 then 8'hC0.
REQ-032 Light sample equal to light_level (128) -> l_thresh=01; light sample 127 -> l_thresh=00.
REQ-033 Assert reset at bit 9 of the light frame -> adc_cs_n=1 next cycle, m_sense=255, no sample_valid pulse.
REQ-034 Drop enable during the moisture frame -> the set completes with exactly one sample_valid pulse, then adc_cs_n stays high.
REQ-035 SAMPLER_AVG_EN defined, moisture samples 100 then 51 -> m_sense=100 then 75.
